// File: rtl/c17_response_checker_if.sv
// Bundles the c17 checker's session control, vector stream and statistics outputs.
// Latency: none, these are plain wires.
// Backpressure: vec_ready is the only flow control, and the checker drives it from its state.
interface c17_response_checker_if #(
  parameter int CNT_W  = 16,
  parameter int MISR_W = 16
);
  logic              start;
  logic              stop;
  logic              vec_valid;
  logic [4:0]        vec_in;
  logic [1:0]        dut_out;
  logic              vec_ready;
  logic              busy;
  logic              done;
  logic              alarm;
  logic [CNT_W-1:0]  vec_count;
  logic [CNT_W-1:0]  mismatch_count;
  logic [CNT_W-1:0]  first_fail_idx;
  logic [4:0]        first_fail_vec;
  logic [1:0]        first_fail_out;
  logic [MISR_W-1:0] signature;

  // Stimulus side: applies vectors and observed responses, reads back statistics.
  modport master (
    output start, stop, vec_valid, vec_in, dut_out,
    input  vec_ready, busy, done, alarm, vec_count, mismatch_count,
           first_fail_idx, first_fail_vec, first_fail_out, signature
  );

  // Checker side.
  modport slave (
    input  start, stop, vec_valid, vec_in, dut_out,
    output vec_ready, busy, done, alarm, vec_count, mismatch_count,
           first_fail_idx, first_fail_vec, first_fail_out, signature
  );
endinterface

// File: rtl/c17_response_checker.sv
// Compares observed c17 outputs against a built-in golden model, counts mismatches, keeps the first failure, compacts responses into a MISR.
// Latency: statistics update on the accept edge and are visible the following cycle; vec_ready follows the state register.
// Backpressure: accepts one vector per cycle while in RUN or ALARM, otherwise vec_ready is low and vec_valid is ignored.
module c17_response_checker #(
  parameter int          CNT_W        = 16,
  parameter int          ALARM_THRESH = 1,
  parameter int          MISR_W       = 16,
  parameter logic [63:0] MISR_POLY    = 64'h1021
) (
  input logic                    clk,
  input logic                    rst,
  c17_response_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM, DONE} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  THRESH  = CNT_W'(ALARM_THRESH);
  localparam logic [MISR_W-1:0] POLY    = MISR_POLY[MISR_W-1:0];

  state_t state_q, state_d;

  logic [CNT_W-1:0]  vec_count_q;
  logic [CNT_W-1:0]  mismatch_count_q;
  logic [CNT_W-1:0]  first_fail_idx_q;
  logic [4:0]        first_fail_vec_q;
  logic [1:0]        first_fail_out_q;
  logic [MISR_W-1:0] signature_q;
  logic              alarm_q;

  // Golden c17 netlist, evaluated on the applied vector.
  logic n1, n2, n3, n6, n7;
  logic n10, n11, n16, n19, n22g, n23g;

  assign {n1, n2, n3, n6, n7} = bus.vec_in;
  assign n10  = ~(n1 & n3);
  assign n11  = ~(n3 & n6);
  assign n16  = ~(n2 & n11);
  assign n19  = ~(n11 & n7);
  assign n22g = ~(n10 & n16);
  assign n23g = ~(n16 & n19);

  logic              ready;
  logic              accept;
  logic              mismatch;
  logic              alarm_hit;
  logic [CNT_W-1:0]  vec_count_inc;
  logic [CNT_W-1:0]  mismatch_count_inc;
  logic [MISR_W-1:0] signature_nxt;

  assign ready    = (state_q == RUN) || (state_q == ALARM);
  assign accept   = bus.vec_valid & ready;
  assign mismatch = accept && (bus.dut_out != {n22g, n23g});

  // Counters hold at all-ones rather than wrapping.
  assign vec_count_inc      = (vec_count_q == CNT_MAX) ? vec_count_q : vec_count_q + 1'b1;
  assign mismatch_count_inc = (mismatch_count_q == CNT_MAX) ? mismatch_count_q
                                                            : mismatch_count_q + 1'b1;

  // Threshold is judged on the count this mismatch produces, so alarm rises on the same edge.
  assign alarm_hit = mismatch && (mismatch_count_inc >= THRESH);

  assign signature_nxt = {signature_q[MISR_W-2:0], 1'b0}
                       ^ (signature_q[MISR_W-1] ? POLY : '0)
                       ^ {{(MISR_W-2){1'b0}}, bus.dut_out};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start beats everything, stop only ends an active session, stop beats the alarm transition.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.stop)     state_d = DONE;
          else if (alarm_hit) state_d = ALARM;
        end
        ALARM: begin
          if (bus.stop) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Session statistics: cleared by start; a vector arriving with start was evaluated on the old state and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count_q      <= '0;
      mismatch_count_q <= '0;
      first_fail_idx_q <= '0;
      first_fail_vec_q <= '0;
      first_fail_out_q <= '0;
      signature_q      <= '0;
      alarm_q          <= 1'b0;
    end else if (bus.start) begin
      vec_count_q      <= '0;
      mismatch_count_q <= '0;
      first_fail_idx_q <= '0;
      first_fail_vec_q <= '0;
      first_fail_out_q <= '0;
      signature_q      <= '0;
      alarm_q          <= 1'b0;
    end else if (accept) begin
      vec_count_q <= vec_count_inc;
      signature_q <= signature_nxt;
      if (mismatch) begin
        mismatch_count_q <= mismatch_count_inc;
        if (mismatch_count_q == '0) begin
          first_fail_idx_q <= vec_count_q;
          first_fail_vec_q <= bus.vec_in;
          first_fail_out_q <= bus.dut_out;
        end
      end
      if (alarm_hit) alarm_q <= 1'b1;
    end
  end

  assign bus.vec_ready      = ready;
  assign bus.busy           = ready;
  assign bus.done           = (state_q == DONE);
  assign bus.alarm          = alarm_q;
  assign bus.vec_count      = vec_count_q;
  assign bus.mismatch_count = mismatch_count_q;
  assign bus.first_fail_idx = first_fail_idx_q;
  assign bus.first_fail_vec = first_fail_vec_q;
  assign bus.first_fail_out = first_fail_out_q;
  assign bus.signature      = signature_q;

endmodule

// File: tb/tb_c17_response_checker.sv
// Drives two checker instances (default widths, and a 4-bit counter / threshold-3 build) against a reference model.
// Latency: expected statistics are queued when a cycle is driven and compared just after the following rising edge.
// Backpressure: the model tracks vec_ready from its own copy of the session state.
module tb_c17_response_checker;

  logic clk;
  logic rst;

  c17_response_checker_if #(.CNT_W(16), .MISR_W(16)) bus_a ();
  c17_response_checker_if #(.CNT_W(4),  .MISR_W(16)) bus_b ();

  c17_response_checker #(.CNT_W(16), .ALARM_THRESH(1), .MISR_W(16), .MISR_POLY(64'h1021)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  c17_response_checker #(.CNT_W(4), .ALARM_THRESH(3), .MISR_W(16), .MISR_POLY(64'h1021)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [31:0] vc, mm, ffi, ffv, ffo, sig;
    bit          alarm, ready, busy, done;
  } exp_t;

  typedef struct {
    logic [4:0] vi;
    logic [1:0] dout;
    int         exp_mm;
    bit         exp_alarm;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state for whichever instance is under test.
  int          m_state;  // 0 idle, 1 run, 2 alarm, 3 done
  int          m_vc, m_mm, m_ffi, m_max, m_th;
  logic [4:0]  m_ffv;
  logic [1:0]  m_ffo;
  logic [15:0] m_sig;
  bit          m_alarm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Sum-of-products form of the c17 outputs.
  function automatic logic [1:0] ref_out(input logic [4:0] v);
    logic a, b, c, e, f;
    {a, b, c, e, f} = v;
    return {(a & c) | (b & ~(c & e)), ~(c & e) & (b | f)};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
  endfunction

  function automatic exp_t read_dut(input bit sel);
    exp_t r;
    r.sel = sel;
    if (sel) begin
      r.vc = 32'(bus_b.vec_count); r.mm = 32'(bus_b.mismatch_count); r.ffi = 32'(bus_b.first_fail_idx);
      r.ffv = 32'(bus_b.first_fail_vec); r.ffo = 32'(bus_b.first_fail_out); r.sig = 32'(bus_b.signature);
      r.alarm = bus_b.alarm; r.ready = bus_b.vec_ready; r.busy = bus_b.busy; r.done = bus_b.done;
    end else begin
      r.vc = 32'(bus_a.vec_count); r.mm = 32'(bus_a.mismatch_count); r.ffi = 32'(bus_a.first_fail_idx);
      r.ffv = 32'(bus_a.first_fail_vec); r.ffo = 32'(bus_a.first_fail_out); r.sig = 32'(bus_a.signature);
      r.alarm = bus_a.alarm; r.ready = bus_a.vec_ready; r.busy = bus_a.busy; r.done = bus_a.done;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_vc = 0; m_mm = 0; m_ffi = 0; m_ffv = '0; m_ffo = '0; m_sig = '0; m_alarm = 1'b0;
  endtask

  // Drive one cycle on the selected instance and queue the expected post-edge statistics.
  task automatic drive(input bit sel, input bit st, input bit sp, input bit v,
                       input logic [4:0] vi, input logic [1:0] d);
    bit   rdy, hit, mis;
    exp_t e;
    @(negedge clk);
    bus_a.start = sel ? 1'b0 : st;  bus_b.start = sel ? st : 1'b0;
    bus_a.stop  = sel ? 1'b0 : sp;  bus_b.stop  = sel ? sp : 1'b0;
    bus_a.vec_valid = sel ? 1'b0 : v; bus_b.vec_valid = sel ? v : 1'b0;
    bus_a.vec_in = vi; bus_b.vec_in = vi;
    bus_a.dut_out = d; bus_b.dut_out = d;
    m_max = sel ? 15 : 65535;
    m_th  = sel ? 3 : 1;
    rdy = (m_state == 1) || (m_state == 2);
    hit = 1'b0;
    if (st) begin
      model_clear();
      m_state = 1;
    end else begin
      if (v && rdy) begin
        mis = (d != ref_out(vi));
        if (mis && m_mm == 0) begin m_ffi = m_vc; m_ffv = vi; m_ffo = d; end
        if (m_vc < m_max) m_vc++;
        if (mis && m_mm < m_max) m_mm++;
        if (mis && m_mm >= m_th) begin m_alarm = 1'b1; hit = 1'b1; end
        m_sig = misr(m_sig, d);
      end
      if (sp && rdy) m_state = 3;
      else if (m_state == 1 && hit) m_state = 2;
    end
    e.sel = sel; e.vc = m_vc; e.mm = m_mm; e.ffi = m_ffi; e.ffv = 32'(m_ffv); e.ffo = 32'(m_ffo);
    e.sig = 32'(m_sig); e.alarm = m_alarm;
    e.ready = (m_state == 1) || (m_state == 2); e.busy = e.ready; e.done = (m_state == 3);
    sb.push_back(e);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) drive(sel, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic chk_zero(input bit sel, input string tag);
    exp_t r;
    r = read_dut(sel);
    chk({tag, "_vc"}, r.vc, 0);   chk({tag, "_mm"}, r.mm, 0);   chk({tag, "_ffi"}, r.ffi, 0);
    chk({tag, "_ffv"}, r.ffv, 0); chk({tag, "_ffo"}, r.ffo, 0); chk({tag, "_sig"}, r.sig, 0);
    chk({tag, "_alarm"}, 32'(r.alarm), 0); chk({tag, "_ready"}, 32'(r.ready), 0);
    chk({tag, "_busy"}, 32'(r.busy), 0);   chk({tag, "_done"}, 32'(r.done), 0);
  endtask

  // Scoreboard: each queued expectation is compared just after the edge that consumed its stimulus.
  always @(posedge clk) begin
    #2;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_a = read_dut(mon_e.sel);
      chk("sb_vec_count", mon_a.vc, mon_e.vc);
      chk("sb_mismatch_count", mon_a.mm, mon_e.mm);
      chk("sb_first_fail_idx", mon_a.ffi, mon_e.ffi);
      chk("sb_first_fail_vec", mon_a.ffv, mon_e.ffv);
      chk("sb_first_fail_out", mon_a.ffo, mon_e.ffo);
      chk("sb_signature", mon_a.sig, mon_e.sig);
      chk("sb_alarm", 32'(mon_a.alarm), 32'(mon_e.alarm));
      chk("sb_vec_ready", 32'(mon_a.ready), 32'(mon_e.ready));
      chk("sb_busy", 32'(mon_a.busy), 32'(mon_e.busy));
      chk("sb_done", 32'(mon_a.done), 32'(mon_e.done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [11];
    exp_t       r;
    logic [4:0] v5;

    for (int i = 0; i < 7; i++) begin
      v5 = 5'(i * 3 + 1);
      tbl[i] = '{v5, ref_out(v5), 0, 1'b0};
    end
    tbl[7]  = '{5'b10101, 2'b01, 1, 1'b1};
    tbl[8]  = '{5'b00000, 2'b00, 1, 1'b1};
    tbl[9]  = '{5'b11111, 2'b10, 1, 1'b1};
    tbl[10] = '{5'b11111, 2'b11, 2, 1'b1};

    bus_a.start = 0; bus_a.stop = 0; bus_a.vec_valid = 0; bus_a.vec_in = '0; bus_a.dut_out = '0;
    bus_b.start = 0; bus_b.stop = 0; bus_b.vec_valid = 0; bus_b.vec_in = '0; bus_b.dut_out = '0;
    m_state = 0; model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(1'b0, "rst_a");
    chk_zero(1'b1, "rst_b");
    rst = 1'b0;

    // vec_valid while IDLE is ignored.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 2'b11);

    // All 32 vectors with golden responses.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 32; i++) begin
      v5 = 5'(i);
      drive(1'b0, 1'b0, 1'b0, 1'b1, v5, ref_out(v5));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    idle(1'b0, 1);
    settle();
    r = read_dut(1'b0);
    chk("all32_vec_count", r.vc, 32);
    chk("all32_mismatch", r.mm, 0);
    chk("all32_alarm", 32'(r.alarm), 0);
    chk("all32_done", 32'(r.done), 1);
    chk("all32_ffi", r.ffi, 0);

    // vec_valid while DONE is ignored, even with wrong responses.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 5'b10101, 2'b00);

    // First failure capture and alarm from the table.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, tbl[i].vi, tbl[i].dout);
      settle();
      r = read_dut(1'b0);
      chk("tbl_mismatch", r.mm, 32'(tbl[i].exp_mm));
      chk("tbl_alarm", 32'(r.alarm), 32'(tbl[i].exp_alarm));
      chk("tbl_vec_count", r.vc, 32'(i + 1));
    end
    r = read_dut(1'b0);
    chk("ff_idx", r.ffi, 7);
    chk("ff_vec", r.ffv, 32'h15);
    chk("ff_out", r.ffo, 32'h1);
    chk("alarm_busy", 32'(r.busy), 1);

    // start and stop together: start wins.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    settle();
    r = read_dut(1'b0);
    chk("ss_busy", 32'(r.busy), 1);
    chk("ss_done", 32'(r.done), 0);
    chk("ss_vec_count", r.vc, 0);
    chk("ss_alarm", 32'(r.alarm), 0);

    // MISR steps and clear on start.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'b11);
    settle();
    r = read_dut(1'b0);
    chk("misr_step1", r.sig, 32'h0003);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 2'b01);
    settle();
    r = read_dut(1'b0);
    chk("misr_step2", r.sig, 32'h0007);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 2'b01);
    settle();
    r = read_dut(1'b0);
    chk("misr_clear", r.sig, 32'h0000);
    chk("start_drops_vec", r.vc, 0);

    // Asynchronous reset in the middle of a session.
    for (int i = 0; i < 5; i++) begin
      v5 = 5'(i * 5 + 2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, v5, ref_out(v5));
    end
    settle();
    r = read_dut(1'b0);
    chk("pre_rst_vec_count", r.vc, 5);
    rst = 1'b1;
    #1;
    chk_zero(1'b0, "midrst");
    bus_a.vec_valid = 1'b0;
    m_state = 0; model_clear();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      v5 = 5'(i + 20);
      drive(1'b0, 1'b0, 1'b0, 1'b1, v5, (i == 1) ? ~ref_out(v5) : ref_out(v5));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    idle(1'b0, 1);

    // Narrow counters: alarm at the third mismatch, saturation at 15, signature keeps moving.
    m_state = 0; model_clear();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      v5 = 5'($urandom_range(0, 31));
      drive(1'b1, 1'b0, 1'b0, 1'b1, v5, ~ref_out(v5));
      settle();
      r = read_dut(1'b1);
      chk("sat_alarm", 32'(r.alarm), (i >= 2) ? 32'd1 : 32'd0);
    end
    r = read_dut(1'b1);
    chk("sat_vec_count", r.vc, 15);
    chk("sat_mismatch", r.mm, 15);
    chk("sat_busy", 32'(r.busy), 1);
    idle(1'b1, 2);

    settle();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
